pop_count_serializer: RTL and testbench

- Inverse of the datapath's 7-bit ones-counter.
- Accepts a 3-bit population count through a valid/ready handshake and expands it to a 7-bit thermometer word (the k lowest bits set).
- Streams that word out serially, MSB first, under output backpressure.
- Used as the stimulus/loopback end for the counter, so a bench can reconstruct input patterns and compare them against the counter's 3-bit result.

---
 rtl/pop_count_serializer_pkg.sv | 13 +
 rtl/pop_count_serializer_therm_decode.sv | 28 ++
 rtl/pop_count_serializer.sv | 90 +++++++++
 tb/tb_pop_count_serializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pop_count_serializer_pkg.sv
// Shared definitions for the pop-count serializer: FSM encoding and
// default geometry (7-bit frames driven from a 3-bit count).
package pop_count_serializer_pkg;

  localparam int DEF_WIDTH = 7;
  localparam int DEF_CNT_W = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/pop_count_serializer_therm_decode.sv
// Count to thermometer decoder: word has the k lowest bits set, where
// k = min(cnt, WIDTH); sat flags a count that had to be clipped to WIDTH.
module pop_count_serializer_therm_decode #(
  parameter int WIDTH = 7,
  parameter int CNT_W = 3
) (
  input  logic [CNT_W-1:0] cnt,
  output logic [WIDTH-1:0] word,
  output logic             sat
);

  // One extra bit so WIDTH itself (up to 2**CNT_W) is representable.
  localparam int KW = CNT_W + 1;
  localparam logic [KW-1:0] WIDTH_K = KW'(WIDTH);

  logic [KW-1:0] k;

  // Clip the count, then set every bit position below it.
  always_comb begin
    sat  = ({1'b0, cnt} > WIDTH_K);
    k    = sat ? WIDTH_K : {1'b0, cnt};
    word = '0;
    for (int i = 0; i < WIDTH; i++) begin
      word[i] = (KW'(i) < k);
    end
  end

endmodule

// File: rtl/pop_count_serializer.sv
// Pop-count serializer: accepts a population count, expands it to a
// thermometer word and streams that word MSB first, so zeros leave first
// and the k ones close the frame.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on state (never on in_valid); out_valid, out_bit
// and out_last depend only on registers (never on out_ready) and hold
// steady while the consumer stalls.
module pop_count_serializer
  import pop_count_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic [WIDTH-1:0] out_word,
  output logic             sat,
  output logic [7:0]       frame_cnt
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  // Observable FSM state and bit pointer (kept as plain named signals).
  state_t           state;
  logic [IDX_W-1:0] idx;

  logic [WIDTH-1:0] dec_word;
  logic             dec_sat;

  pop_count_serializer_therm_decode #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_decode (
    .cnt (in_cnt),
    .word(dec_word),
    .sat (dec_sat)
  );

  // Handshake and stream outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_SEND);
    out_bit   = out_valid && out_word[idx];
    out_last  = out_valid && (idx == '0);
  end

  // FSM, bit pointer, captured word, saturation pulse and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= IDX_TOP;
      out_word  <= '0;
      sat       <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      sat <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            out_word <= dec_word;
            idx      <= IDX_TOP;
            sat      <= dec_sat;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (out_ready) begin
            if (idx != '0) begin
              idx <= idx - IDX_W'(1);
            end else begin
              state     <= ST_IDLE;
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pop_count_serializer.sv
// Directed bench for pop_count_serializer: a default 7-bit instance and a
// 4-bit instance (to reach saturation), driven by one linear sequence.
module tb_pop_count_serializer;

  logic       clk = 1'b0;
  logic       reset;

  // Default instance (WIDTH=7, CNT_W=3)
  logic       in_valid, in_ready, out_valid, out_ready, out_bit, out_last, sat;
  logic [2:0] in_cnt;
  logic [6:0] out_word;
  logic [7:0] frame_cnt;

  // Narrow instance (WIDTH=4, CNT_W=3)
  logic       in_valid4, in_ready4, out_valid4, out_ready4, out_bit4, out_last4, sat4;
  logic [2:0] in_cnt4;
  logic [3:0] out_word4;
  logic [7:0] frame_cnt4;

  int checks   = 0;
  int failures = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  pop_count_serializer u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cnt(in_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_last(out_last), .out_word(out_word), .sat(sat), .frame_cnt(frame_cnt)
  );

  pop_count_serializer #(.WIDTH(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_cnt(in_cnt4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_bit(out_bit4),
    .out_last(out_last4), .out_word(out_word4), .sat(sat4), .frame_cnt(frame_cnt4)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: hold reset for two edges.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Driver: present one count for a single accept edge.
  task automatic send(input string tag, input logic [2:0] cnt, input bit use4);
    check({tag, "_in_ready"}, use4 ? in_ready4 : in_ready, 1);
    if (use4) begin in_valid4 = 1'b1; in_cnt4 = cnt; end
    else      begin in_valid  = 1'b1; in_cnt  = cnt; end
    tick();
    in_valid  = 1'b0;
    in_valid4 = 1'b0;
  endtask

  // Checks on one bit slot of the stream.
  task automatic check_slot(input string tag, input logic exp_bit, input int i,
                            input logic exp_sat, input bit use4);
    check({tag, "_out_valid"}, use4 ? out_valid4 : out_valid, 1);
    check({tag, "_in_ready_busy"}, use4 ? in_ready4 : in_ready, 0);
    check($sformatf("%s_bit%0d", tag, i), use4 ? out_bit4 : out_bit, exp_bit);
    check($sformatf("%s_last%0d", tag, i), use4 ? out_last4 : out_last, (i == 0));
    check($sformatf("%s_sat%0d", tag, i), use4 ? sat4 : sat, exp_sat);
    if (!use4) check($sformatf("%s_idx%0d", tag, i), u_dut.idx, i);
  endtask

  // Driver/receiver: consume nbits of a frame of width w, optionally with
  // an out_ready pattern of 1,0,0,1,0,0,...
  task automatic recv(input string tag, input logic [6:0] exp_word, input int w,
                      input int nbits, input bit stall, input logic exp_sat,
                      input bit use4);
    logic s_now;
    for (int i = w - 1; i >= w - nbits; i--) begin
      s_now = (i == w - 1) ? exp_sat : 1'b0;
      if (stall && i != w - 1) begin
        for (int s = 0; s < 2; s++) begin
          if (use4) out_ready4 = 1'b0; else out_ready = 1'b0;
          check_slot({tag, "_stall"}, exp_word[i], i, s_now, use4);
          tick();
        end
      end
      if (use4) out_ready4 = 1'b1; else out_ready = 1'b1;
      check_slot(tag, exp_word[i], i, s_now, use4);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_cnt = '0; out_ready = 1'b1;
    in_valid4 = 1'b0; in_cnt4 = '0; out_ready4 = 1'b1;

    // Reset state
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_word", out_word, 7'd0);
    check("rst_frame_cnt", frame_cnt, 8'd0);
    check("rst_sat", sat, 0);
    check("rst_idx", u_dut.idx, 6);

    // count 3 -> 0000111
    send("c3", 3'd3, 0);
    check("c3_word", out_word, 7'b0000111);
    recv("c3", 7'b0000111, 7, 7, 0, 1'b0, 0);
    check("c3_frame_cnt", frame_cnt, 8'd1);
    check("c3_in_ready_after", in_ready, 1);
    check("c3_out_valid_after", out_valid, 0);
    check("c3_word_hold", out_word, 7'b0000111);

    // count 0 then 7, back-to-back
    do_reset();
    send("c0", 3'd0, 0);
    check("c0_word", out_word, 7'b0000000);
    recv("c0", 7'b0000000, 7, 7, 0, 1'b0, 0);
    send("c7", 3'd7, 0);
    check("c7_word", out_word, 7'b1111111);
    recv("c7", 7'b1111111, 7, 7, 0, 1'b0, 0);
    check("c07_frame_cnt", frame_cnt, 8'd2);

    // count 5 under backpressure
    send("c5", 3'd5, 0);
    check("c5_word", out_word, 7'b0011111);
    recv("c5", 7'b0011111, 7, 7, 1, 1'b0, 0);
    check("c5_frame_cnt", frame_cnt, 8'd3);
    check("c5_idle", out_valid, 0);

    // Narrow instance saturates: 6 clipped to 4
    send("w4", 3'd6, 1);
    check("w4_word", out_word4, 4'b1111);
    recv("w4", 7'b0001111, 4, 4, 0, 1'b1, 1);
    check("w4_frame_cnt", frame_cnt4, 8'd1);
    check("w4_sat_cleared", sat4, 0);

    // Abort a count-4 frame after three bits
    send("ab", 3'd4, 0);
    recv("ab", 7'b0001111, 7, 3, 0, 1'b0, 0);
    reset = 1'b1;
    tick();
    check("ab_out_valid", out_valid, 0);
    check("ab_out_last", out_last, 0);
    check("ab_frame_cnt", frame_cnt, 8'd0);
    check("ab_out_word", out_word, 7'd0);
    check("ab_in_ready", in_ready, 1);

    // Reset and in_valid together: nothing accepted
    in_valid = 1'b1; in_cnt = 3'd2;
    tick();
    in_valid = 1'b0;
    reset = 1'b0;
    check("rv_out_valid", out_valid, 0);
    check("rv_out_word", out_word, 7'd0);
    tick();
    check("rv_still_idle", out_valid, 0);

    // 256 frames of count 1: frame counter wraps
    for (int f = 0; f < 256; f++) begin
      send("wr", 3'd1, 0);
      recv("wr", 7'b0000001, 7, 7, 0, 1'b0, 0);
      if (f == 254) check("wr_frame_cnt_255", frame_cnt, 8'd255);
    end
    check("wr_frame_cnt_wrap", frame_cnt, 8'd0);
    check("wr_in_ready", in_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
